// File: rtl/ascon_control_fsm_if.sv
// Handshake and datapath-control bundle between the Ascon sequencer, its block source
// and the permutation datapath.
interface ascon_control_fsm_if;
    // upstream request / block handshake
    logic       i_start;
    logic [3:0] i_num_ad;
    logic [3:0] i_num_pt;
    logic       i_data_valid;
    logic       o_data_ready;

    // permutation datapath controls
    logic       o_sys_enable;
    logic       o_mux_select;
    logic       o_enable_xor_key_begin;
    logic       o_enable_xor_data_begin;
    logic       o_enable_xor_key_end;
    logic       o_enable_xor_lsb_end;
    logic       o_enable_state_reg;
    logic       o_enable_cipher_reg;
    logic       o_enable_tag_reg;
    logic [3:0] o_round;

    // status
    logic       o_cipher_valid;
    logic       o_done;
    logic       o_busy;

    modport slave (
        input  i_start, i_num_ad, i_num_pt, i_data_valid,
        output o_data_ready, o_sys_enable, o_mux_select,
               o_enable_xor_key_begin, o_enable_xor_data_begin,
               o_enable_xor_key_end, o_enable_xor_lsb_end,
               o_enable_state_reg, o_enable_cipher_reg, o_enable_tag_reg,
               o_round, o_cipher_valid, o_done, o_busy
    );

    modport master (
        output i_start, i_num_ad, i_num_pt, i_data_valid,
        input  o_data_ready, o_sys_enable, o_mux_select,
               o_enable_xor_key_begin, o_enable_xor_data_begin,
               o_enable_xor_key_end, o_enable_xor_lsb_end,
               o_enable_state_reg, o_enable_cipher_reg, o_enable_tag_reg,
               o_round, o_cipher_valid, o_done, o_busy
    );
endinterface

// File: rtl/ascon_control_fsm.sv
// Sequencer for the Ascon-128 permutation datapath: init, AD blocks, PT blocks, finalization.
// Control outputs are decoded from state/round (Mealy on i_data_valid in the WAIT states).
module ascon_control_fsm #(
    parameter int unsigned NUM_ROUNDS_A = 12,
    parameter int unsigned NUM_ROUNDS_B = 6
) (
    input  logic                clock,
    input  logic                reset_n,
    ascon_control_fsm_if.slave  ctrl
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned RND_W = 4;

    localparam logic [RND_W-1:0] RND_LAST  = RND_W'(NUM_ROUNDS_A - 1);
    localparam logic [RND_W-1:0] RND_BLK   = RND_W'(NUM_ROUNDS_A - NUM_ROUNDS_B);
    localparam logic [RND_W-1:0] RND_BLK_N = RND_W'(NUM_ROUNDS_A - NUM_ROUNDS_B + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_WAIT_AD = 3'd2;
    localparam logic [2:0] S_AD_RND  = 3'd3;
    localparam logic [2:0] S_WAIT_PT = 3'd4;
    localparam logic [2:0] S_PT_RND  = 3'd5;
    localparam logic [2:0] S_FINAL   = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [RND_W-1:0] rnd_q, rnd_d;
    logic [CNT_W-1:0] ad_cnt_q, ad_cnt_d;
    logic [CNT_W-1:0] pt_cnt_q, pt_cnt_d;
    logic             cipher_valid_q, cipher_valid_d;

    logic             data_ready_c;
    logic             mux_select_c;
    logic             xor_key_begin_c;
    logic             xor_data_begin_c;
    logic             xor_key_end_c;
    logic             xor_lsb_end_c;
    logic             state_reg_c;
    logic             cipher_reg_c;
    logic             tag_reg_c;
    logic [RND_W-1:0] round_c;
    logic             done_c;
    logic             busy_c;

    // State, round and block-counter registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            rnd_q          <= '0;
            ad_cnt_q       <= '0;
            pt_cnt_q       <= '0;
            cipher_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rnd_q          <= rnd_d;
            ad_cnt_q       <= ad_cnt_d;
            pt_cnt_q       <= pt_cnt_d;
            cipher_valid_q <= cipher_valid_d;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d          = state_q;
        rnd_d            = rnd_q;
        ad_cnt_d         = ad_cnt_q;
        pt_cnt_d         = pt_cnt_q;
        data_ready_c     = 1'b0;
        mux_select_c     = 1'b0;
        xor_key_begin_c  = 1'b0;
        xor_data_begin_c = 1'b0;
        xor_key_end_c    = 1'b0;
        xor_lsb_end_c    = 1'b0;
        state_reg_c      = 1'b0;
        cipher_reg_c     = 1'b0;
        tag_reg_c        = 1'b0;
        round_c          = '0;
        done_c           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ctrl.i_start) begin
                    ad_cnt_d = ctrl.i_num_ad;
                    pt_cnt_d = (ctrl.i_num_pt == '0) ? CNT_W'(1) : ctrl.i_num_pt;
                    rnd_d    = '0;
                    state_d  = S_INIT;
                end
            end

            S_INIT: begin
                mux_select_c = (rnd_q != '0);
                state_reg_c  = 1'b1;
                round_c      = rnd_q;
                if (rnd_q == RND_LAST) begin
                    xor_key_end_c = 1'b1;
                    rnd_d         = '0;
                    // With no AD the domain-separation bit goes in right after init
                    if (ad_cnt_q == '0) begin
                        xor_lsb_end_c = 1'b1;
                        state_d       = S_WAIT_PT;
                    end else begin
                        state_d       = S_WAIT_AD;
                    end
                end else begin
                    rnd_d = rnd_q + RND_W'(1);
                end
            end

            S_WAIT_AD: begin
                data_ready_c = 1'b1;
                if (ctrl.i_data_valid) begin
                    mux_select_c     = 1'b1;
                    xor_data_begin_c = 1'b1;
                    state_reg_c      = 1'b1;
                    round_c          = RND_BLK;
                    rnd_d            = RND_BLK_N;
                    state_d          = S_AD_RND;
                end
            end

            S_AD_RND: begin
                mux_select_c = 1'b1;
                state_reg_c  = 1'b1;
                round_c      = rnd_q;
                if (rnd_q == RND_LAST) begin
                    ad_cnt_d = ad_cnt_q - CNT_W'(1);
                    rnd_d    = '0;
                    if (ad_cnt_q <= CNT_W'(1)) begin
                        xor_lsb_end_c = 1'b1;
                        state_d       = S_WAIT_PT;
                    end else begin
                        state_d       = S_WAIT_AD;
                    end
                end else begin
                    rnd_d = rnd_q + RND_W'(1);
                end
            end

            S_WAIT_PT: begin
                data_ready_c = 1'b1;
                if (ctrl.i_data_valid) begin
                    mux_select_c     = 1'b1;
                    xor_data_begin_c = 1'b1;
                    state_reg_c      = 1'b1;
                    cipher_reg_c     = 1'b1;
                    // Last PT block starts the pa finalization at round 0
                    if (pt_cnt_q <= CNT_W'(1)) begin
                        xor_key_begin_c = 1'b1;
                        round_c         = '0;
                        pt_cnt_d        = '0;
                        rnd_d           = RND_W'(1);
                        state_d         = S_FINAL;
                    end else begin
                        round_c         = RND_BLK;
                        rnd_d           = RND_BLK_N;
                        state_d         = S_PT_RND;
                    end
                end
            end

            S_PT_RND: begin
                mux_select_c = 1'b1;
                state_reg_c  = 1'b1;
                round_c      = rnd_q;
                if (rnd_q == RND_LAST) begin
                    pt_cnt_d = pt_cnt_q - CNT_W'(1);
                    rnd_d    = '0;
                    state_d  = S_WAIT_PT;
                end else begin
                    rnd_d = rnd_q + RND_W'(1);
                end
            end

            S_FINAL: begin
                mux_select_c = 1'b1;
                state_reg_c  = 1'b1;
                round_c      = rnd_q;
                if (rnd_q == RND_LAST) begin
                    xor_key_end_c = 1'b1;
                    tag_reg_c     = 1'b1;
                    rnd_d         = '0;
                    state_d       = S_DONE;
                end else begin
                    rnd_d = rnd_q + RND_W'(1);
                end
            end

            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                rnd_d   = '0;
            end
        endcase
    end

    assign busy_c         = (state_q != S_IDLE);
    assign cipher_valid_d = cipher_reg_c;

    assign ctrl.o_data_ready            = data_ready_c;
    assign ctrl.o_sys_enable            = busy_c;
    assign ctrl.o_mux_select            = mux_select_c;
    assign ctrl.o_enable_xor_key_begin  = xor_key_begin_c;
    assign ctrl.o_enable_xor_data_begin = xor_data_begin_c;
    assign ctrl.o_enable_xor_key_end    = xor_key_end_c;
    assign ctrl.o_enable_xor_lsb_end    = xor_lsb_end_c;
    assign ctrl.o_enable_state_reg      = state_reg_c;
    assign ctrl.o_enable_cipher_reg     = cipher_reg_c;
    assign ctrl.o_enable_tag_reg        = tag_reg_c;
    assign ctrl.o_round                 = round_c;
    assign ctrl.o_cipher_valid          = cipher_valid_q;
    assign ctrl.o_done                  = done_c;
    assign ctrl.o_busy                  = busy_c;

endmodule

// File: tb/tb_ascon_control_fsm.sv
// Bench for ascon_control_fsm: a cycle schedule is built from block counts and stall
// lengths, then every cycle's control outputs are compared against it.
module tb_ascon_control_fsm;

    localparam logic [16:0] M_FULL  = 17'h1FFFF;
    localparam logic [16:0] M_STALL = 17'h1FF87;  // round index is don't-care while stalled
    localparam int B_CR = 8;
    localparam int B_CV = 2;
    localparam int B_DN = 1;

    typedef struct {
        logic [16:0] exp;
        logic [16:0] mask;
        bit          valid;
        bit          start;
    } ent_t;

    logic clock;
    logic reset_n;
    ascon_control_fsm_if bus ();

    ascon_control_fsm #(.NUM_ROUNDS_A(12), .NUM_ROUNDS_B(6)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .ctrl    (bus)
    );

    always #5 clock = ~clock;

    int   tests_run    = 0;
    int   tests_failed = 0;
    ent_t sched[$];
    bit   vfill;

    // {ready, sys, mux, key_begin, data_begin, key_end, lsb_end, state, cipher, tag, round, cv, done, busy}
    function automatic logic [16:0] mk(input bit rdy, input bit act, input bit mux, input bit kb,
                                       input bit db, input bit ke, input bit le, input bit sr,
                                       input bit cr, input bit tr, input int rnd, input bit dn);
        return {rdy, act, mux, kb, db, ke, le, sr, cr, tr, 4'(rnd), 1'b0, dn, act};
    endfunction

    function automatic logic [16:0] observe();
        return {bus.o_data_ready, bus.o_sys_enable, bus.o_mux_select,
                bus.o_enable_xor_key_begin, bus.o_enable_xor_data_begin,
                bus.o_enable_xor_key_end, bus.o_enable_xor_lsb_end,
                bus.o_enable_state_reg, bus.o_enable_cipher_reg, bus.o_enable_tag_reg,
                bus.o_round, bus.o_cipher_valid, bus.o_done, bus.o_busy};
    endfunction

    function automatic bit fillv();
        return vfill ? 1'b1 : 1'($urandom_range(1, 0));
    endfunction

    function automatic void add(input logic [16:0] e, input logic [16:0] m, input bit v, input bit s);
        ent_t x;
        x.exp   = e;
        x.mask  = m;
        x.valid = v;
        x.start = s;
        sched.push_back(x);
    endfunction

    task automatic check(input string tag, input int cyc, input logic [16:0] obs, input logic [16:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Expected per-cycle schedule of one whole message, starting with the start cycle
    task automatic build(input int nad, input int npe, input int first_stall,
                         input int max_stall, output int stalls);
        int  s;
        bit  is_ad;
        bit  last;
        sched.delete();
        stalls = 0;
        add(mk(0,0,0,0,0,0,0,0,0,0,0,0), M_FULL, fillv(), 1'b1);
        for (int r = 0; r < 12; r++)
            add(mk(0,1,r != 0,0,0,r == 11,(r == 11) && (nad == 0),1,0,0,r,0), M_FULL, fillv(), 1'b0);
        for (int b = 0; b < nad + npe; b++) begin
            is_ad = (b < nad);
            last  = (b == nad + npe - 1);
            s     = (b == 0) ? first_stall : int'($urandom_range(max_stall, 0));
            stalls += s;
            for (int k = 0; k < s; k++)
                add(mk(1,1,0,0,0,0,0,0,0,0,0,0), M_STALL, 1'b0, 1'b0);
            add(mk(1,1,1,last,1,0,0,1,!is_ad,0,last ? 0 : 6,0), M_FULL, 1'b1, 1'b0);
            if (!last) begin
                for (int r = 7; r <= 11; r++)
                    add(mk(0,1,1,0,0,0,is_ad && (r == 11) && (b == nad - 1),1,0,0,r,0), M_FULL,
                        fillv(), is_ad ? 1'b0 : 1'($urandom_range(1, 0)));
            end else begin
                for (int r = 1; r <= 11; r++)
                    add(mk(0,1,1,0,0,r == 11,0,1,0,r == 11,r,0), M_FULL, fillv(), 1'b0);
                add(mk(0,1,0,0,0,0,0,0,0,0,0,1), M_FULL, fillv(), 1'b0);
            end
        end
        add(mk(0,0,0,0,0,0,0,0,0,0,0,0), M_FULL, fillv(), 1'b0);
        add(mk(0,0,0,0,0,0,0,0,0,0,0,0), M_FULL, fillv(), 1'b0);
        // cipher_valid follows the cipher register enable by one cycle
        for (int i = 1; i < sched.size(); i++)
            sched[i].exp[B_CV] = sched[i-1].exp[B_CR];
    endtask

    task automatic run_case(input string tag, input int nad, input int npt,
                            input int first_stall, input int max_stall, input bit vf);
        int npe;
        int stalls;
        int done_idx;
        int cv_cnt;
        logic [16:0] obs;
        vfill    = vf;
        npe      = (npt == 0) ? 1 : npt;
        done_idx = -1;
        cv_cnt   = 0;
        build(nad, npe, first_stall, max_stall, stalls);
        for (int i = 0; i < sched.size(); i++) begin
            @(posedge clock);
            #1;
            bus.i_start      = sched[i].start;
            bus.i_data_valid = sched[i].valid;
            bus.i_num_ad     = (i == 0) ? 4'(nad) : 4'($urandom);
            bus.i_num_pt     = (i == 0) ? 4'(npt) : 4'($urandom);
            @(negedge clock);
            obs = observe();
            check(tag, i, obs & sched[i].mask, sched[i].exp & sched[i].mask);
            if (obs[B_DN] === 1'b1 && done_idx < 0) done_idx = i;
            if (obs[B_CV] === 1'b1) cv_cnt++;
        end
        bus.i_start      = 1'b0;
        bus.i_data_valid = 1'b0;
        check({tag, "_latency"}, done_idx, 17'(done_idx), 17'(13 + 6 * (nad + npe - 1) + 12 + stalls));
        check({tag, "_cv_pulses"}, cv_cnt, 17'(cv_cnt), 17'(npe));
    endtask

    initial begin
        clock            = 1'b0;
        reset_n          = 1'b0;
        bus.i_start      = 1'b0;
        bus.i_num_ad     = 4'd0;
        bus.i_num_pt     = 4'd0;
        bus.i_data_valid = 1'b0;
        vfill            = 1'b0;

        // outputs quiet under reset even with requests present
        #12;
        bus.i_start      = 1'b1;
        bus.i_data_valid = 1'b1;
        #1;
        check("reset_outputs", 0, observe(), 17'h0);
        @(negedge clock);
        bus.i_start      = 1'b0;
        bus.i_data_valid = 1'b0;
        reset_n          = 1'b1;
        @(negedge clock);
        check("idle_after_reset", 0, observe(), 17'h0);

        run_case("ad0_pt1", 0, 1, 0, 0, 1'b1);
        run_case("ad2_pt3", 2, 3, 0, 0, 1'b0);
        run_case("stall_ad", 1, 2, 10, 0, 1'b0);
        run_case("pt_zero", 1, 0, 0, 1, 1'b0);

        // reset during INIT aborts at once
        @(posedge clock);
        #1;
        bus.i_start  = 1'b1;
        bus.i_num_ad = 4'd1;
        bus.i_num_pt = 4'd1;
        @(posedge clock);
        #1;
        bus.i_start  = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("init_rnd5", 0, observe(), mk(0,1,1,0,0,0,0,1,0,0,5,0));
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_mid_init", 0, observe(), 17'h0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_after_abort", 0, observe(), 17'h0);
        run_case("post_reset", 3, 2, 0, 2, 1'b0);

        for (int n = 0; n < 6; n++)
            run_case("random", int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), 0, 3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ascon_control_fsm.md
# ascon_control_fsm

Sequencing controller for the Ascon-128 permutation datapath. It drives every control input of the permutation: mux select, begin/end XOR enables, register enables and round index. It steps the datapath through initialization, associated data, plaintext and finalization. It also runs a valid/ready handshake with the upstream block source and flags when cipher blocks and the tag are available.

## Interface
- NUM_ROUNDS_A, 12, round count of initialization and finalization (pa)
- NUM_ROUNDS_B, 6, round count per data block (pb); first round index = NUM_ROUNDS_A − NUM_ROUNDS_B
- clock  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- i_start  input  1  start request, sampled in IDLE only
- i_num_ad  input  4  AD block count (0..15), latched on start
- i_num_pt  input  4  plaintext block count (1..15), latched on start; 0 treated as 1
- i_data_valid  input  1  upstream 64-bit block present on datapath i_data
- o_data_ready  output  1  controller accepts a block this cycle
- o_sys_enable  output  1  datapath system enable
- o_mux_select  output  1  0 = load external state, 1 = feed back register
- o_enable_xor_key_begin, o_enable_xor_data_begin  output  1 each  begin-XOR enables
- o_enable_xor_key_end, o_enable_xor_lsb_end  output  1 each  end-XOR enables
- o_enable_state_reg, o_enable_cipher_reg, o_enable_tag_reg  output  1 each  datapath register enables
- o_round  output  4  round constant index
- o_cipher_valid  output  1  one-cycle pulse: datapath o_cipher holds a new block
- o_done  output  1  one-cycle pulse: datapath o_tag valid
- o_busy  output  1  high in every state except IDLE

## Operation
- States: IDLE, INIT, WAIT_AD, AD_RND, WAIT_PT, PT_RND, FINAL, DONE. There is a 4-bit round counter `rnd` and 4-bit remaining-block counters for AD and PT.
- **IDLE:** all outputs 0. On i_start, latch the counts and go to INIT with rnd=0.
- **INIT** (12 cycles):
  - rnd=0: mux_select=0, all other cycles 1.
  - state_reg=1 and o_round=rnd throughout.
  - At rnd=11: xor_key_end=1. If the AD count is 0, also assert xor_lsb_end=1 and go to WAIT_PT; otherwise go to WAIT_AD.
- **WAIT_AD / WAIT_PT:**
  - o_data_ready=1.
  - While i_data_valid=0, all enables are 0 except sys_enable, and the state holds.
  - On i_data_valid=1 (the acceptance cycle), the first block round executes combinationally in the same cycle: mux_select=1, xor_data_begin=1, state_reg=1.
  - Non-final block: o_round=6.
  - WAIT_PT acceptance also asserts cipher_reg=1.
  - Final PT block: xor_key_begin=1 and o_round=0, then go to FINAL with rnd=1. Otherwise go to AD_RND or PT_RND with rnd=7.
- **AD_RND / PT_RND:**
  - mux_select=1, state_reg=1, o_round=rnd for rnd=7..11.
  - At rnd=11, decrement the block counter.
  - Last AD block at rnd=11: xor_lsb_end=1 (domain separation) and go to WAIT_PT.
  - Otherwise return to the matching WAIT state.
- **FINAL:**
  - rnd=1..11, mux_select=1, state_reg=1.
  - At rnd=11: xor_key_end=1 and tag_reg=1, then go to DONE.
- **DONE:** one cycle with o_done=1, then go to IDLE.
- o_sys_enable = o_busy.
- o_cipher_valid is a registered copy of cipher_reg, so it is high the cycle after acceptance.
- i_start outside IDLE is ignored.
- i_data_valid outside the WAIT states is ignored, and o_data_ready=0 there.

## Timing
- Reset:
  - State = IDLE; rnd and both counters = 0.
  - All outputs 0, including o_done, o_cipher_valid, o_busy and o_round.
  - Reset mid-operation aborts immediately with no pending pulses.
- Start accepted at cycle T → INIT rnd=0 at T+1 → INIT rnd=11 at T+12 → WAIT state from T+13.
- Each block occupies 6 cycles: the acceptance cycle plus 5 rounds. The next o_data_ready is high 6 cycles after acceptance at the earliest.
- Final PT acceptance at cycle A: FINAL at A+1..A+11, tag_reg at A+11, o_done at A+12, IDLE at A+13.
- With zero upstream stall: total latency from start to o_done = 13 + 6·(num_ad + num_pt − 1) + 12 cycles.
- Control outputs are combinational from state and rnd (Mealy on i_data_valid in the WAIT states only). Upstream must hold i_data valid during the acceptance cycle only.

## Test plan
- **Reset during INIT:** start, then assert reset_n=0 at rnd=5 → all outputs 0 asynchronously; IDLE after release; a new start runs a full 12-round INIT.
- **num_ad=0, num_pt=1, valid always 1:**
  - INIT asserts xor_key_end and xor_lsb_end at rnd=11.
  - Single acceptance with cipher_reg, xor_key_begin, o_round=0.
  - o_done exactly 25 cycles after the start cycle.
- **num_ad=2, num_pt=3, no stall:**
  - 5 acceptances spaced 6 cycles apart.
  - xor_lsb_end only at the second AD block's rnd=11.
  - o_cipher_valid pulses 3 times.
  - o_done at 13+24+12 = 49 cycles after start.
- **Stall:** hold i_data_valid=0 for 10 cycles in WAIT_AD → o_data_ready stays 1, state_reg stays 0, o_round is don't-care; the schedule resumes unchanged.
- **Ignored inputs:**
  - i_start pulsed during PT_RND → no effect.
  - i_num_pt=0 → behaves as one PT block.
  - o_round sequence in each PT_RND is 7,8,9,10,11.
- **Full-length Ascon-128 known-answer vector:** controller wired to the permutation datapath → cipher blocks and tag match the reference model bit-exact.
